// File: rtl/ifu_fetch_unit_pkg.sv
// Shared core definitions: fetch FSM states, AXI read response codes and the reset PC
// shared with the WBU PC generator.
package ifu_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_PC,
        S_AR,
        S_R,
        S_OUT
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] RESET_PC    = 32'h2000_0000;

endpackage

// File: rtl/ifu_fetch_unit_if.sv
// Fetch-stage signal bundle: WBU->IFU PC handshake, AXI4-Lite read channels, IFU->IDU handshake.
// The fetch unit takes the slave view; the surrounding core/memory take the master view.
interface ifu_fetch_unit_if;

    logic        wbu_valid;
    logic [31:0] pc_in;
    logic        ifu_ready;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        ifu_valid;
    logic        idu_ready;

    modport master (
        output wbu_valid, pc_in, arready, rdata, rresp, rvalid, idu_ready,
        input  ifu_ready, araddr, arvalid, rready, inst, inst_pc, inst_fault, ifu_valid
    );

    modport slave (
        input  wbu_valid, pc_in, arready, rdata, rresp, rvalid, idu_ready,
        output ifu_ready, araddr, arvalid, rready, inst, inst_pc, inst_fault, ifu_valid
    );

endinterface

// File: rtl/ifu_perf_counter.sv
// Enable-increment performance counter with synchronous reset; wraps modulo 2^Width.
module ifu_perf_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + Width'(1);
        end
    end

endmodule

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch stage: one PC in, one single-beat read, one instruction out.
// All outputs come straight from registers; at most one fetch is in flight.
module ifu_fetch_unit #(
    parameter logic [31:0] RESET_PC  = ifu_fetch_unit_pkg::RESET_PC,
    parameter logic [1:0]  OKAY_RESP = ifu_fetch_unit_pkg::RESP_OKAY
) (
    input  logic                   clk,
    input  logic                   rst,
    ifu_fetch_unit_if.slave        bus,
    output logic [63:0]            fetch_cnt
);

    import ifu_fetch_unit_pkg::*;

    ifu_state_e  state_q;
    logic        ifu_ready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        ifu_valid_q;
    logic        inst_fault_q;
    logic [31:0] araddr_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        deliver;

    assign deliver = (state_q == S_OUT) & ifu_valid_q & bus.idu_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_PC;
            ifu_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            ifu_valid_q  <= 1'b0;
            araddr_q     <= '0;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_PC: begin
                    if (bus.wbu_valid && ifu_ready_q) begin
                        araddr_q    <= bus.pc_in;
                        inst_pc_q   <= bus.pc_in;
                        ifu_ready_q <= 1'b0;
                        if (bus.pc_in[1:0] == 2'b00) begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_AR;
                        end else begin
                            // Misaligned PC: skip the bus and hand a faulting slot downstream.
                            inst_q       <= '0;
                            inst_fault_q <= 1'b1;
                            ifu_valid_q  <= 1'b1;
                            state_q      <= S_OUT;
                        end
                    end
                end
                S_AR: begin
                    if (arvalid_q && bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (bus.rvalid && rready_q) begin
                        inst_q       <= bus.rdata;
                        inst_fault_q <= (bus.rresp != OKAY_RESP);
                        rready_q     <= 1'b0;
                        ifu_valid_q  <= 1'b1;
                        state_q      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (ifu_valid_q && bus.idu_ready) begin
                        ifu_valid_q <= 1'b0;
                        ifu_ready_q <= 1'b1;
                        state_q     <= S_PC;
                    end
                end
                default: state_q <= S_PC;
            endcase
        end
    end

    assign bus.ifu_ready  = ifu_ready_q;
    assign bus.araddr     = araddr_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.rready     = rready_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_fault = inst_fault_q;
    assign bus.ifu_valid  = ifu_valid_q;

    ifu_perf_counter #(
        .Width(64)
    ) u_fetch_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (deliver),
        .count(fetch_cnt)
    );

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Self-checking bench for ifu_fetch_unit: directed scenarios plus randomized fetches checked
// against a transaction-level model (latency = stalls + fixed overhead, data/fault from rules).
module tb_ifu_fetch_unit;

    import ifu_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fetch_cnt;
    logic [63:0] cnt_exp;
    int          n_cmp  = 0;
    int          n_fail = 0;

    ifu_fetch_unit_if bus ();

    ifu_fetch_unit #(
        .RESET_PC (32'h2000_0000),
        .OKAY_RESP(2'b00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        bus.wbu_valid = 1'b0;
        bus.pc_in     = '0;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = '0;
        bus.idu_ready = 1'b0;
    endtask

    // Memory/IDU driver: plays one fetch at the given stall counts and reports what it saw.
    // Must be called at a negedge; returns at the negedge after the IDU handshake edge.
    task automatic do_fetch(input logic [31:0] pc, input int ar_stall, input int r_stall,
                            input int idu_stall, input logic [31:0] data, input logic [1:0] resp,
                            input bit toggle, output int valid_at, output logic [31:0] o_inst,
                            output logic [31:0] o_pc, output logic o_fault, output int ar_cyc,
                            output int ar_hs, output int bad_addr, output int bad_stable,
                            output int bad_ready, output int bad_inv, output bit ready_first,
                            output bit timeout);
        int  ar_c = 0, r_c = 0, v_c = 0;
        bit  done = 1'b0;
        valid_at = -1; o_inst = '0; o_pc = '0; o_fault = 1'b0;
        ar_cyc = 0; ar_hs = 0; bad_addr = 0; bad_stable = 0; bad_ready = 0; bad_inv = 0;
        timeout = 1'b1;
        ready_first = bus.ifu_ready;
        set_idle();
        bus.wbu_valid = 1'b1;
        bus.pc_in     = pc;
        for (int i = 0; i < 20 && !bus.ifu_ready; i++) @(negedge clk);
        if (!bus.ifu_ready) return;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin
                set_idle();
                timeout = 1'b0;
                return;
            end
            bus.wbu_valid = toggle ? 1'($urandom) : 1'b0;
            bus.pc_in     = toggle ? $urandom : 32'h0;
            if (bus.ifu_ready && bus.ifu_valid) bad_inv++;
            if (bus.arvalid && bus.rready) bad_inv++;
            if (bus.ifu_ready) bad_ready++;
            if (bus.arvalid) begin
                ar_cyc++;
                if (bus.araddr !== pc) bad_addr++;
                bus.arready = (ar_c == ar_stall);
                if (bus.arready) ar_hs++;
                ar_c++;
            end else begin
                bus.arready = 1'($urandom);
            end
            if (bus.rready) begin
                bus.rvalid = (r_c == r_stall);
                bus.rdata  = bus.rvalid ? data : $urandom;
                bus.rresp  = bus.rvalid ? resp : 2'($urandom);
                r_c++;
            end else begin
                bus.rvalid = 1'b0;
                bus.rdata  = $urandom;
            end
            if (bus.ifu_valid) begin
                if (valid_at < 0) begin
                    valid_at = n;
                    o_inst   = bus.inst;
                    o_pc     = bus.inst_pc;
                    o_fault  = bus.inst_fault;
                end else if (bus.inst !== o_inst || bus.inst_pc !== o_pc ||
                             bus.inst_fault !== o_fault) begin
                    bad_stable++;
                end
                bus.idu_ready = (v_c == idu_stall);
                done = bus.idu_ready;
                v_c++;
            end else begin
                bus.idu_ready = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cnt_exp = '0;
        n_cmp++; if (bus.ifu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ifu_ready: got %b want 1", bus.ifu_ready); end
        n_cmp++; if (bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", bus.arvalid); end
        n_cmp++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b want 0", bus.rready); end
        n_cmp++; if (bus.ifu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ifu_valid: got %b want 0", bus.ifu_valid); end
        n_cmp++; if (bus.araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %h want 0", bus.araddr); end
        n_cmp++; if (bus.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
        n_cmp++; if (bus.inst_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_inst_pc: got %h want %h", bus.inst_pc, RESET_PC); end
        n_cmp++; if (bus.inst_fault !== 1'b0) begin n_fail++; $display("FAIL reset_inst_fault: got %b want 0", bus.inst_fault); end
        n_cmp++; if (fetch_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_fetch_cnt: got %0d want 0", fetch_cnt); end
    endtask

    task automatic test_basic();
        int v_at, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv;
        logic [31:0] i_d, i_p; logic i_f; bit rf, to;
        do_fetch(32'h2000_0000, 0, 0, 0, 32'h0000_0413, RESP_OKAY, 1'b0,
                 v_at, i_d, i_p, i_f, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv, rf, to);
        cnt_exp++;
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to); end
        n_cmp++; if (v_at !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", v_at); end
        n_cmp++; if (i_d !== 32'h0000_0413) begin n_fail++; $display("FAIL basic_inst: got %h want 00000413", i_d); end
        n_cmp++; if (i_p !== 32'h2000_0000) begin n_fail++; $display("FAIL basic_inst_pc: got %h want 20000000", i_p); end
        n_cmp++; if (i_f !== 1'b0) begin n_fail++; $display("FAIL basic_fault: got %b want 0", i_f); end
        n_cmp++; if (ar_cyc !== 1 || b_addr !== 0) begin n_fail++; $display("FAIL basic_ar: got cyc %0d badaddr %0d want 1/0", ar_cyc, b_addr); end
        n_cmp++; if (bus.araddr !== 32'h2000_0000) begin n_fail++; $display("FAIL basic_araddr: got %h want 20000000", bus.araddr); end
        n_cmp++; if (fetch_cnt !== cnt_exp) begin n_fail++; $display("FAIL basic_fetch_cnt: got %0d want %0d", fetch_cnt, cnt_exp); end
    endtask

    task automatic test_stall();
        int v_at, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv;
        logic [31:0] i_d, i_p; logic i_f; bit rf, to;
        do_fetch(32'h2000_0010, 4, 3, 0, 32'h1234_5678, RESP_OKAY, 1'b0,
                 v_at, i_d, i_p, i_f, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv, rf, to);
        cnt_exp++;
        n_cmp++; if (v_at !== 10) begin n_fail++; $display("FAIL stall_latency: got %0d want 10", v_at); end
        n_cmp++; if (ar_cyc !== 5) begin n_fail++; $display("FAIL stall_arvalid_cycles: got %0d want 5", ar_cyc); end
        n_cmp++; if (ar_hs !== 1) begin n_fail++; $display("FAIL stall_ar_count: got %0d want 1", ar_hs); end
        n_cmp++; if (b_addr !== 0) begin n_fail++; $display("FAIL stall_araddr_stable: got %0d bad want 0", b_addr); end
        n_cmp++; if (i_d !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_inst: got %h want 12345678", i_d); end
        n_cmp++; if (b_inv !== 0) begin n_fail++; $display("FAIL stall_invariants: got %0d want 0", b_inv); end
        n_cmp++; if (fetch_cnt !== cnt_exp) begin n_fail++; $display("FAIL stall_fetch_cnt: got %0d want %0d", fetch_cnt, cnt_exp); end
    endtask

    task automatic test_misaligned();
        int v_at, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv;
        logic [31:0] i_d, i_p; logic i_f; bit rf, to;
        do_fetch(32'h2000_0002, 0, 0, 0, 32'hFFFF_FFFF, RESP_OKAY, 1'b0,
                 v_at, i_d, i_p, i_f, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv, rf, to);
        cnt_exp++;
        n_cmp++; if (v_at !== 1) begin n_fail++; $display("FAIL misal_latency: got %0d want 1", v_at); end
        n_cmp++; if (ar_cyc !== 0) begin n_fail++; $display("FAIL misal_arvalid: got %0d cycles want 0", ar_cyc); end
        n_cmp++; if (i_f !== 1'b1) begin n_fail++; $display("FAIL misal_fault: got %b want 1", i_f); end
        n_cmp++; if (i_d !== 32'h0) begin n_fail++; $display("FAIL misal_inst: got %h want 0", i_d); end
        n_cmp++; if (i_p !== 32'h2000_0002) begin n_fail++; $display("FAIL misal_inst_pc: got %h want 20000002", i_p); end
        n_cmp++; if (fetch_cnt !== cnt_exp) begin n_fail++; $display("FAIL misal_fetch_cnt: got %0d want %0d", fetch_cnt, cnt_exp); end
    endtask

    task automatic test_slverr();
        int v_at, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv;
        logic [31:0] i_d, i_p; logic i_f; bit rf, to;
        do_fetch(32'h2000_0020, 1, 1, 0, 32'hDEAD_BEEF, RESP_SLVERR, 1'b0,
                 v_at, i_d, i_p, i_f, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv, rf, to);
        cnt_exp++;
        n_cmp++; if (i_d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL slverr_inst: got %h want deadbeef", i_d); end
        n_cmp++; if (i_f !== 1'b1) begin n_fail++; $display("FAIL slverr_fault: got %b want 1", i_f); end
        n_cmp++; if (v_at !== 5) begin n_fail++; $display("FAIL slverr_latency: got %0d want 5", v_at); end
        n_cmp++; if (fetch_cnt !== cnt_exp) begin n_fail++; $display("FAIL slverr_fetch_cnt: got %0d want %0d", fetch_cnt, cnt_exp); end
    endtask

    task automatic test_back_to_back();
        int v_at, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv;
        logic [31:0] i_d, i_p; logic i_f; bit rf, to;
        do_fetch(32'h2000_0030, 0, 0, 5, 32'hCAFE_0001, RESP_OKAY, 1'b1,
                 v_at, i_d, i_p, i_f, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv, rf, to);
        cnt_exp++;
        n_cmp++; if (b_stab !== 0) begin n_fail++; $display("FAIL bp_out_stable: got %0d bad want 0", b_stab); end
        n_cmp++; if (b_rdy !== 0) begin n_fail++; $display("FAIL bp_ifu_ready_low: got %0d bad want 0", b_rdy); end
        n_cmp++; if (i_p !== 32'h2000_0030) begin n_fail++; $display("FAIL bp_inst_pc: got %h want 20000030", i_p); end
        n_cmp++; if (fetch_cnt !== cnt_exp) begin n_fail++; $display("FAIL bp_fetch_cnt: got %0d want %0d", fetch_cnt, cnt_exp); end
        do_fetch(32'h2000_0034, 0, 0, 0, 32'hCAFE_0002, RESP_OKAY, 1'b0,
                 v_at, i_d, i_p, i_f, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv, rf, to);
        cnt_exp++;
        n_cmp++; if (rf !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_next: got %b want 1", rf); end
        n_cmp++; if (v_at !== 3 || i_p !== 32'h2000_0034) begin n_fail++; $display("FAIL b2b_fetch: got lat %0d pc %h want 3/20000034", v_at, i_p); end
        n_cmp++; if (fetch_cnt !== cnt_exp) begin n_fail++; $display("FAIL b2b_fetch_cnt: got %0d want %0d", fetch_cnt, cnt_exp); end
    endtask

    task automatic test_reset_in_r();
        int bad = 0;
        set_idle();
        bus.wbu_valid = 1'b1;
        bus.pc_in     = 32'h2000_0100;
        bus.arready   = 1'b1;
        @(negedge clk);
        bus.wbu_valid = 1'b0;
        @(negedge clk);
        bus.arready = 1'b0;
        n_cmp++; if (bus.rready !== 1'b1) begin n_fail++; $display("FAIL rst_reach_r: got rready %b want 1", bus.rready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt_exp = '0;
        n_cmp++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL rst_r_rready: got %b want 0", bus.rready); end
        n_cmp++; if (bus.ifu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_r_ifu_ready: got %b want 1", bus.ifu_ready); end
        n_cmp++; if (bus.inst_pc !== RESET_PC) begin n_fail++; $display("FAIL rst_r_inst_pc: got %h want %h", bus.inst_pc, RESET_PC); end
        n_cmp++; if (fetch_cnt !== cnt_exp) begin n_fail++; $display("FAIL rst_r_fetch_cnt: got %0d want 0", fetch_cnt); end
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hBAD0_BAD0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ifu_valid !== 1'b0 || bus.rready !== 1'b0 || bus.inst !== 32'h0) bad++;
        end
        set_idle();
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rst_r_late_rvalid: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_random();
        int v_at, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv, ars, rs, ids, lat_exp;
        logic [31:0] i_d, i_p, pc, data, inst_exp; logic i_f, fault_exp, misal; logic [1:0] resp;
        bit rf, to;
        int errs;
        for (int it = 0; it < 40; it++) begin
            pc = 32'h2000_0000 | ($urandom & 32'h000F_FFFC);
            misal = ($urandom_range(0, 3) == 0);
            if (misal) pc[1:0] = 2'($urandom_range(1, 3));
            ars = $urandom_range(0, 3); rs = $urandom_range(0, 3); ids = $urandom_range(0, 2);
            data = $urandom; resp = 2'($urandom);
            do_fetch(pc, ars, rs, ids, data, resp, 1'($urandom),
                     v_at, i_d, i_p, i_f, ar_cyc, ar_hs, b_addr, b_stab, b_rdy, b_inv, rf, to);
            cnt_exp++;
            lat_exp   = misal ? 1 : 3 + ars + rs;
            inst_exp  = misal ? 32'h0 : data;
            fault_exp = misal || (resp != RESP_OKAY);
            errs = 0;
            if (to) errs++;
            if (v_at != lat_exp) errs++;
            if (i_d !== inst_exp || i_p !== pc || i_f !== fault_exp) errs++;
            if (ar_hs != (misal ? 0 : 1) || b_addr != 0) errs++;
            if (b_stab != 0 || b_rdy != 0 || b_inv != 0 || rf !== 1'b1) errs++;
            if (fetch_cnt !== cnt_exp) errs++;
            n_cmp++;
            if (errs != 0) begin
                n_fail++;
                $display("FAIL rand_%0d: got pc %h lat %0d inst %h fault %b cnt %0d ar %0d want lat %0d inst %h fault %b cnt %0d ar %0d",
                         it, pc, v_at, i_d, i_f, fetch_cnt, ar_hs, lat_exp, inst_exp, fault_exp,
                         cnt_exp, misal ? 0 : 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_misaligned();
        test_slverr();
        test_back_to_back();
        test_reset_in_r();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
